// File: rtl/idct_8x8_engine_if.sv
// Stream interface for the 8x8 IDCT engine.
// Coefficient side: in_valid / in_ready / in_coef (signed, raster order, beat 0 = DC).
// Pixel side: out_valid / out_ready / out_pix (unsigned 8-bit) / out_last (beat 63).
// busy reports that the engine is computing or draining a block.
// slave  : the engine side (accepts coefficients, produces pixels).
// master : the source/sink side (drives coefficients, consumes pixels).
interface idct_8x8_engine_if #(
  parameter int COEF_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [COEF_W-1:0] in_coef;
  logic                     out_valid;
  logic                     out_ready;
  logic [7:0]               out_pix;
  logic                     out_last;
  logic                     busy;

  modport slave (
    input  in_valid, in_coef, out_ready,
    output in_ready, out_valid, out_pix, out_last, busy
  );

  modport master (
    output in_valid, in_coef, out_ready,
    input  in_ready, out_valid, out_pix, out_last, busy
  );
endinterface

// File: rtl/idct_8x8_engine.sv
// Inverse 2-D 8x8 DCT engine.
// Loads 64 signed coefficients, runs a row pass (64 outputs x 8 MACs) into a
// 20-bit transpose buffer, runs a column pass (64 x 8 MACs) into a pixel
// buffer with level shift and [0,255] clamp, then streams the 64 pixels out.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (discards any block in flight)
//   bus   : idct_8x8_engine_if.slave (coefficient in / pixel out streams, busy)
module idct_8x8_engine #(
  parameter int COEF_W      = 16,
  parameter int LEVEL_SHIFT = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  idct_8x8_engine_if.slave      bus
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic signed [39:0] LVL = 40'(LEVEL_SHIFT);

  // Q12 basis C(k,n) = round(4096*a(k)*cos((2n+1)k*pi/16)), a(0)=sqrt(1/8), a(k>0)=1/2.
  // The angle index m=(2n+1)k mod 32 is folded onto the first quadrant of
  // 2048*cos(j*pi/16), j=0..8, and the sign restored afterwards.
  function automatic logic signed [13:0] cos_coef(input logic [2:0] k, input logic [2:0] n);
    logic [7:0]  prod;
    logic [4:0]  m;
    logic [3:0]  j;
    logic        neg;
    logic [13:0] mag;
    prod = {4'd0, n, 1'b1} * {5'd0, k};
    m    = prod[4:0];
    if (m <= 5'd8) begin
      j = m[3:0]; neg = 1'b0;
    end else if (m <= 5'd16) begin
      j = 4'(5'd16 - m); neg = 1'b1;
    end else if (m <= 5'd24) begin
      j = 4'(m - 5'd16); neg = 1'b1;
    end else begin
      j = 4'(6'd32 - {1'b0, m}); neg = 1'b0;
    end
    case (j)
      4'd0:    mag = 14'd2048;
      4'd1:    mag = 14'd2009;
      4'd2:    mag = 14'd1892;
      4'd3:    mag = 14'd1703;
      4'd4:    mag = 14'd1448;
      4'd5:    mag = 14'd1138;
      4'd6:    mag = 14'd784;
      4'd7:    mag = 14'd400;
      default: mag = 14'd0;
    endcase
    if (k == 3'd0) begin
      cos_coef = 14'sd1448;
    end else if (neg) begin
      cos_coef = -$signed(mag);
    end else begin
      cos_coef = $signed(mag);
    end
  endfunction

  state_t             state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [5:0]         odx_q, odx_d;
  logic signed [39:0] acc_q, acc_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [7:0]         out_pix_q, out_pix_d;

  logic signed [COEF_W-1:0] coef_mem_q [64];
  logic signed [19:0]       t_mem_q    [64];
  logic [7:0]               pix_mem_q  [64];

  logic                     coef_we_s;
  logic [5:0]               coef_wa_s;
  logic signed [COEF_W-1:0] coef_wd_s;
  logic                     t_we_s;
  logic [5:0]               t_wa_s;
  logic signed [19:0]       t_wd_s;
  logic                     pix_we_s;
  logic [5:0]               pix_wa_s;
  logic [7:0]               pix_wd_s;

  logic [2:0]         basis_n_s;
  logic signed [13:0] basis_s;
  logic signed [19:0] opnd_s;
  logic signed [33:0] prod_s;
  logic signed [39:0] sum_s;
  logic signed [39:0] rnd_s;
  logic signed [39:0] pv_s;
  logic [7:0]         pix_val_s;

  // Shared MAC datapath: cnt[2:0] is the summation index in both passes.
  // Row pass: output {k1,n2}=cnt[8:3], operand X(k1,k2), basis C(k2,n2).
  // Column pass: output {n1,n2}=cnt[8:3], operand T(k1,n2), basis C(k1,n1).
  always_comb begin
    basis_n_s = 3'd0;
    opnd_s    = 20'sd0;
    if (state_q == ST_PASS1) begin
      basis_n_s = cnt_q[5:3];
      opnd_s    = 20'(coef_mem_q[{cnt_q[8:6], cnt_q[2:0]}]);
    end else begin
      basis_n_s = cnt_q[8:6];
      opnd_s    = t_mem_q[{cnt_q[2:0], cnt_q[5:3]}];
    end
    basis_s = cos_coef(cnt_q[2:0], basis_n_s);
    prod_s  = basis_s * opnd_s;
    if (cnt_q[2:0] == 3'd0) begin
      sum_s = 40'(prod_s);
    end else begin
      sum_s = acc_q + 40'(prod_s);
    end
    rnd_s = (sum_s + 40'sd2048) >>> 12;
    pv_s  = rnd_s + LVL;
    if (pv_s < 40'sd0) begin
      pix_val_s = 8'd0;
    end else if (pv_s > 40'sd255) begin
      pix_val_s = 8'd255;
    end else begin
      pix_val_s = pv_s[7:0];
    end
  end

  // Next-state, counters, buffer write controls and output register updates.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    odx_d       = odx_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_pix_d   = out_pix_q;
    coef_we_s   = 1'b0;
    coef_wa_s   = idx_q;
    coef_wd_s   = bus.in_coef;
    t_we_s      = 1'b0;
    t_wa_s      = cnt_q[8:3];
    t_wd_s      = rnd_s[19:0];
    pix_we_s    = 1'b0;
    pix_wa_s    = cnt_q[8:3];
    pix_wd_s    = pix_val_s;
    case (state_q)
      ST_LOAD: begin
        if (bus.in_valid) begin
          coef_we_s = 1'b1;
          idx_d     = idx_q + 6'd1;
          if (idx_q == 6'd63) begin
            state_d = ST_PASS1;
            cnt_d   = 9'd0;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_PASS1: begin
        acc_d  = sum_s;
        t_we_s = (cnt_q[2:0] == 3'd7);
        cnt_d  = cnt_q + 9'd1;
        if (cnt_q == 9'd511) begin
          state_d = ST_PASS2;
        end else begin
          state_d = ST_PASS1;
        end
      end
      ST_PASS2: begin
        acc_d    = sum_s;
        pix_we_s = (cnt_q[2:0] == 3'd7);
        cnt_d    = cnt_q + 9'd1;
        if (cnt_q == 9'd511) begin
          state_d = ST_DRAIN;
          odx_d   = 6'd0;
        end else begin
          state_d = ST_PASS2;
        end
      end
      ST_DRAIN: begin
        // A new beat is loaded whenever the output register is empty or
        // being consumed; everything holds while the sink stalls.
        if (!out_valid_q || bus.out_ready) begin
          if (out_valid_q && out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = ST_LOAD;
          end else begin
            out_pix_d   = pix_mem_q[odx_q];
            out_last_d  = (odx_q == 6'd63);
            out_valid_d = 1'b1;
            odx_d       = odx_q + 6'd1;
          end
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      idx_q       <= 6'd0;
      cnt_q       <= 9'd0;
      odx_q       <= 6'd0;
      acc_q       <= 40'sd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pix_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      odx_q       <= odx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_pix_q   <= out_pix_d;
    end
  end

  // Block buffers; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (coef_we_s) begin
      coef_mem_q[coef_wa_s] <= coef_wd_s;
    end
    if (t_we_s) begin
      t_mem_q[t_wa_s] <= t_wd_s;
    end
    if (pix_we_s) begin
      pix_mem_q[pix_wa_s] <= pix_wd_s;
    end
  end

  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.busy      = (state_q != ST_LOAD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_pix   = out_pix_q;

endmodule
